// File: rtl/write_word_if.sv
// IPIF master-write channel between the tape-capture writer and the DDR bus bridge.
interface write_word_if;
    logic [31:0] ip2bus_mst_addr;
    logic [11:0] ip2bus_mst_length;
    logic [31:0] ip2bus_mstwr_d;
    logic [4:0]  ip2bus_inputs;
    logic [5:0]  ip2bus_otputs;

    modport master (
        output ip2bus_mst_addr,
        output ip2bus_mst_length,
        output ip2bus_mstwr_d,
        output ip2bus_inputs,
        input  ip2bus_otputs
    );

    modport slave (
        input  ip2bus_mst_addr,
        input  ip2bus_mst_length,
        input  ip2bus_mstwr_d,
        input  ip2bus_inputs,
        output ip2bus_otputs
    );
endinterface

// File: rtl/write_word.sv
// Tape-capture writer: buffers 32-bit words and stores each one to consecutive DDR words
// through single-beat IPIF master writes.
module write_word #(
    parameter logic [31:0] BASE_ADDR  = 32'h0020_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         restart,
    input  logic [31:0]  data_in,
    input  logic         write,
    output logic         full,
    output logic         empty,
    output logic         overflow,
    output logic         error,
    output logic         busy,
    output logic [12:0]  words_written,
    write_word_if.master bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_INIT_CMD   = 3'd1;
    localparam logic [2:0] S_START      = 3'd2;
    localparam logic [2:0] S_ACT        = 3'd3;
    localparam logic [2:0] S_WAIT_CMPLT = 3'd4;

    logic [2:0]    r_state, w_state_d;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count, w_count_d;
    logic          r_full, r_empty, r_pending, r_overflow, r_error;
    logic [31:0]   r_addr;
    logic [11:0]   r_len;
    logic [12:0]   r_ww;
    logic          w_push, w_pop, w_apply, w_pending_d, w_bus_err, w_done;
    logic [31:0]   w_head;
    logic [4:0]    w_inputs;
    logic          w_unused;

    assign w_push      = write & ~r_full;
    assign w_pop       = (r_state == S_ACT) & ~bus.ip2bus_otputs[4];
    assign w_apply     = (r_state == S_IDLE) & r_pending;
    assign w_done      = (r_state == S_WAIT_CMPLT) & bus.ip2bus_otputs[1];
    assign w_bus_err   = bus.ip2bus_otputs[2] &
                         ((r_state == S_START) | (r_state == S_ACT) | (r_state == S_WAIT_CMPLT));
    // A new restart pulse wins over the clear so a back-to-back restart is never lost.
    assign w_pending_d = restart | (r_pending & ~w_apply);
    assign w_count_d   = w_apply ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    assign w_unused    = ^{bus.ip2bus_otputs[3], bus.ip2bus_otputs[5]};

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE: begin
                // Same-cycle push starts the command so mstwr_req rises two cycles after write.
                if (!r_pending && !restart && (!r_empty || w_push)) w_state_d = S_INIT_CMD;
            end
            S_INIT_CMD:   w_state_d = S_START;
            S_START:      if (bus.ip2bus_otputs[0]) w_state_d = S_ACT;
            S_ACT:        if (w_pop) w_state_d = S_WAIT_CMPLT;
            S_WAIT_CMPLT: if (w_done) w_state_d = S_IDLE;
            default:      w_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_inputs = 5'b11100;
        if (r_state == S_START) w_inputs = 5'b11111;
        if (r_state == S_ACT)   w_inputs = 5'b00000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_len      <= 12'd0;
            r_ww       <= 13'd0;
        end else begin
            r_state   <= w_state_d;
            r_count   <= w_count_d;
            r_full    <= (w_count_d == DEPTH_C) | w_pending_d;
            r_empty   <= (w_count_d == '0);
            r_pending <= w_pending_d;
            if (r_state == S_INIT_CMD) r_len <= 12'd4;
            if (w_apply) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_addr     <= BASE_ADDR;
                r_ww       <= 13'd0;
                r_overflow <= 1'b0;
                r_error    <= 1'b0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop) r_rptr <= r_rptr + 1'b1;
                if (write && r_full) r_overflow <= 1'b1;
                if (w_bus_err) r_error <= 1'b1;
                if (w_done) begin
                    r_addr <= r_addr + 32'd4;
                    r_ww   <= r_ww + 13'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= data_in;
    end

    assign w_head = r_mem[r_rptr];

    assign full          = r_full;
    assign empty         = r_empty;
    assign overflow      = r_overflow;
    assign error         = r_error;
    assign busy          = (r_state != S_IDLE);
    assign words_written = r_ww;

    assign bus.ip2bus_mst_addr   = r_addr;
    assign bus.ip2bus_mst_length = r_len;
    assign bus.ip2bus_mstwr_d    = {w_head[7:0], w_head[15:8], w_head[23:16], w_head[31:24]};
    assign bus.ip2bus_inputs     = w_inputs;
endmodule

// File: tb/tb_write_word.sv
// Self-checking bench for write_word: a transaction-level model of the capture buffer and
// bus sequence, driven by directed scenarios plus randomized writes, restarts and bus noise.
module tb_write_word;
    localparam logic [31:0] BASE  = 32'h0020_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, restart, write;
    logic [31:0] data_in;
    logic        full, empty, overflow, error, busy;
    logic [12:0] words_written;

    write_word_if u_bus ();

    write_word #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .data_in      (data_in),
        .write        (write),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .error        (error),
        .busy         (busy),
        .words_written(words_written),
        .bus          (u_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 idle, 1 command setup, 2 request, 3 data, 4 completion wait.
    logic [31:0] m_q[$];
    int          m_phase;
    logic [31:0] m_addr;
    logic [12:0] m_ww;
    logic [11:0] m_len;
    bit          m_ovf, m_err, m_pend;
    int          n_pushed;

    int   rsp_cnt, max_dly;
    bit   stall_start, stall_act, stall_cmplt, err_on_cmplt, noise_en, force_en, chk_en;
    logic [5:0] force_val;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic bit m_full_f();
        return (m_q.size() == DEPTH) || m_pend;
    endfunction

    function automatic logic [4:0] exp_inputs(input int ph);
        case (ph)
            2:       return 5'b11111;
            3:       return 5'b00000;
            default: return 5'b11100;
        endcase
    endfunction

    task automatic check_status();
        check_eq("full", full, m_full_f());
        check_eq("empty", empty, m_q.size() == 0);
        check_eq("overflow", overflow, m_ovf);
        check_eq("error", error, m_err);
        check_eq("busy", busy, m_phase != 0);
        check_eq("words_written", words_written, m_ww);
        check_eq("addr", u_bus.ip2bus_mst_addr, m_addr);
        check_eq("length", u_bus.ip2bus_mst_length, m_len);
        check_eq("inputs", u_bus.ip2bus_inputs, exp_inputs(m_phase));
        if (m_q.size() != 0) check_eq("head_data", u_bus.ip2bus_mstwr_d, bswap(m_q[0]));
    endtask

    task automatic drive_bus(input int prev);
        logic [5:0] ot;
        if (m_phase != prev) rsp_cnt = $urandom_range(0, max_dly);
        else if (rsp_cnt > 0) rsp_cnt--;
        ot = noise_en ? 6'($urandom) : 6'b010000;
        ot[2] = noise_en && ($urandom_range(0, 15) == 0);
        case (m_phase)
            2: ot[0] = (rsp_cnt == 0) && !stall_start;
            3: ot[4] = !((rsp_cnt == 0) && !stall_act);
            4: begin
                ot[1] = (rsp_cnt == 0) && !stall_cmplt;
                if (ot[1] && err_on_cmplt) ot[2] = 1'b1;
            end
            default: ;
        endcase
        if (force_en) ot = force_val;
        u_bus.ip2bus_otputs = ot;
    endtask

    task automatic step();
        bit r_rst, mf, push, pop, apply, n_pend, n_ovf, n_err, r_wr, r_rs;
        int n_phase, prev;
        logic [31:0] n_addr, din;
        logic [12:0] n_ww;
        logic [11:0] n_len;
        logic [5:0]  ot;
        r_rst = reset; r_wr = write; r_rs = restart;
        ot = u_bus.ip2bus_otputs; din = data_in;
        if (chk_en && !r_rst) check_status();
        mf = m_full_f();
        push = r_wr && !mf;
        pop = 0; apply = 0;
        n_phase = m_phase; n_addr = m_addr; n_ww = m_ww; n_len = m_len;
        n_ovf = m_ovf || (r_wr && mf);
        n_err = m_err;
        case (m_phase)
            0: if (m_pend) apply = 1;
               else if ((m_q.size() != 0 || push) && !r_rs) n_phase = 1;
            1: begin n_len = 12'd4; n_phase = 2; end
            2: if (ot[0]) n_phase = 3;
            3: if (!ot[4]) begin pop = 1; n_phase = 4; end
            4: if (ot[1]) begin n_addr = m_addr + 32'd4; n_ww = m_ww + 13'd1; n_phase = 0; end
            default: ;
        endcase
        if (m_phase >= 2 && ot[2]) n_err = 1;
        n_pend = r_rs || (m_pend && !apply);
        if (pop && !r_rst) begin
            check_eq("beat_data", u_bus.ip2bus_mstwr_d, bswap(m_q[0]));
            check_eq("beat_addr", u_bus.ip2bus_mst_addr, m_addr);
        end
        prev = m_phase;
        @(posedge clk); #1;
        if (r_rst) begin
            m_q.delete(); m_phase = 0; m_addr = BASE; m_ww = 0; m_len = 0;
            m_ovf = 0; m_err = 0; m_pend = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin m_q.push_back(din); n_pushed++; end
            if (apply) begin
                m_q.delete(); n_addr = BASE; n_ww = 0; n_ovf = 0; n_err = 0;
            end
            m_phase = n_phase; m_addr = n_addr; m_ww = n_ww; m_len = n_len;
            m_ovf = n_ovf; m_err = n_err; m_pend = n_pend;
        end
        drive_bus(prev);
    endtask

    task automatic do_reset();
        reset = 1; write = 0; restart = 0;
        step();
        reset = 0;
    endtask

    task automatic write_word_tb(input logic [31:0] d);
        write = 1; data_in = d;
        step();
        write = 0;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((m_phase != 0 || m_q.size() != 0 || m_pend) && n < budget) begin
            step();
            n++;
        end
        check_eq("idle_budget", n < budget, 1);
    endtask

    task automatic run_until_phase(input int ph, input int budget);
        int n = 0;
        while (m_phase != ph && n < budget) begin
            step();
            n++;
        end
        check_eq("phase_budget", n < budget, 1);
    endtask

    initial begin
        reset = 1; restart = 0; write = 0; data_in = '0;
        u_bus.ip2bus_otputs = 6'b010000;
        max_dly = 1; stall_start = 0; stall_act = 0; stall_cmplt = 0; err_on_cmplt = 0;
        noise_en = 0; force_en = 0; force_val = '0; chk_en = 0; rsp_cnt = 0; n_pushed = 0;
        m_phase = 0;
        do_reset();
        chk_en = 1;

        // Reset state
        check_eq("rst_addr", u_bus.ip2bus_mst_addr, 32'h0020_0000);
        check_eq("rst_inputs", u_bus.ip2bus_inputs, 5'b11100);
        check_eq("rst_empty", empty, 1);

        // Single word: request two cycles after the write strobe
        write_word_tb(32'h1122_3344);
        check_eq("n1_busy", busy, 1);
        step();
        check_eq("n2_req", u_bus.ip2bus_inputs[0], 1);
        check_eq("n2_data", u_bus.ip2bus_mstwr_d, 32'h4433_2211);
        check_eq("n2_addr", u_bus.ip2bus_mst_addr, 32'h0020_0000);
        check_eq("n2_len", u_bus.ip2bus_mst_length, 12'd4);
        run_until_idle(50);
        check_eq("single_ww", words_written, 13'd1);
        check_eq("single_addr", u_bus.ip2bus_mst_addr, 32'h0020_0004);

        // Burst fill with the request stalled
        do_reset();
        stall_start = 1;
        for (int i = 0; i < 6; i++) write_word_tb($urandom);
        check_eq("burst_full", full, 1);
        check_eq("burst_ovf", overflow, 1);
        stall_start = 0;
        run_until_idle(100);
        check_eq("burst_ww", words_written, 13'd4);
        check_eq("burst_addr", u_bus.ip2bus_mst_addr, 32'h0020_0010);

        // Restart while data phase is in flight
        do_reset();
        stall_act = 1;
        for (int i = 0; i < 3; i++) write_word_tb($urandom);
        run_until_phase(3, 20);
        restart = 1; step(); restart = 0;
        check_eq("rst_pend_full", full, 1);
        stall_act = 0;
        run_until_idle(50);
        check_eq("restart_ww", words_written, 13'd0);
        check_eq("restart_addr", u_bus.ip2bus_mst_addr, 32'h0020_0000);
        check_eq("restart_empty", empty, 1);
        write_word_tb(32'hCAFE_F00D);
        run_until_idle(50);
        check_eq("after_restart_addr", u_bus.ip2bus_mst_addr, 32'h0020_0004);

        // Bus error reported with cmplt
        do_reset();
        err_on_cmplt = 1;
        write_word_tb($urandom);
        run_until_idle(50);
        err_on_cmplt = 0;
        check_eq("err_set", error, 1);
        check_eq("err_addr", u_bus.ip2bus_mst_addr, 32'h0020_0004);
        write_word_tb($urandom);
        run_until_idle(50);
        check_eq("err_sticky", error, 1);
        restart = 1; step(); restart = 0;
        step();
        check_eq("err_cleared", error, 0);

        // Reset while waiting for cmplt; later cmplt ignored
        do_reset();
        stall_cmplt = 1;
        write_word_tb($urandom);
        run_until_phase(4, 20);
        reset = 1; step(); reset = 0;
        check_eq("wr_rst_busy", busy, 0);
        check_eq("wr_rst_len", u_bus.ip2bus_mst_length, 12'd0);
        check_eq("wr_rst_inputs", u_bus.ip2bus_inputs, 5'b11100);
        check_eq("wr_rst_empty", empty, 1);
        force_en = 1; force_val = 6'b000011;
        for (int i = 0; i < 3; i++) step();
        force_en = 0; stall_cmplt = 0;
        check_eq("late_cmplt_ww", words_written, 13'd0);
        check_eq("late_cmplt_addr", u_bus.ip2bus_mst_addr, 32'h0020_0000);

        // Randomized writes, restarts and bus noise
        do_reset();
        noise_en = 1; max_dly = 2;
        for (int i = 0; i < 400; i++) begin
            write = ($urandom_range(0, 2) == 0);
            data_in = $urandom;
            restart = ($urandom_range(0, 59) == 0);
            step();
        end
        write = 0; restart = 0; noise_en = 0;
        run_until_idle(200);

        // Counter wrap after 8192 words
        do_reset();
        max_dly = 0; chk_en = 0; n_pushed = 0;
        for (int i = 0; i < 60000 && n_pushed < 8192; i++) begin
            write = !m_full_f();
            data_in = $urandom;
            step();
        end
        write = 0;
        check_eq("wrap_pushes", n_pushed, 8192);
        run_until_idle(100);
        chk_en = 1;
        check_eq("wrap_ww", words_written, 13'd0);
        check_eq("wrap_addr", u_bus.ip2bus_mst_addr, 32'h0020_8000);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
